// File: rtl/prime_pkg.sv
// Shared types and elaboration helpers for the prime display block.
package prime_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StErr
  } state_e;

  function automatic int unsigned prime_width(input int unsigned width_log);
    return 32'd1 << width_log;
  endfunction

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/prime_display_if.sv
// Bundle between the display controller (master) and the prime generator / board side (slave).
interface prime_display_if #(
  parameter int unsigned W     = 16,
  parameter int unsigned NLEDS = 4
);
  logic             pause;
  logic             pg_go;
  logic             pg_ready;
  logic             pg_error;
  logic [W-1:0]     pg_res;
  logic [NLEDS-1:0] leds;
  logic             err_led;

  modport master (
    input  pause,
    input  pg_ready,
    input  pg_error,
    input  pg_res,
    output pg_go,
    output leds,
    output err_led
  );

  modport slave (
    output pause,
    output pg_ready,
    output pg_error,
    output pg_res,
    input  pg_go,
    input  leds,
    input  err_led
  );
endinterface

// File: rtl/tick_gen.sv
// Free-running 0..DIV-1 counter that pulses tick on the last count; holds while en is low.
module tick_gen #(
  parameter int unsigned DIV = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] Last = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q;
    if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/prime_display.sv
// Periodically requests a prime from the generator and shows it on the LEDs.
// Define PRIME_DISPLAY_PAGE_EN to page through the prime one LED-width slice per tick.
module prime_display
  import prime_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 12000000,
  parameter int unsigned PERIOD_MS = 5000,
  parameter int unsigned WIDTH_LOG = 4,
  parameter int unsigned NLEDS     = 4
) (
  input  logic             clk,
  input  logic             rst,
  prime_display_if.master  bus
);
  localparam int unsigned W   = prime_width(WIDTH_LOG);
  localparam int unsigned DIV = CLK_HZ / 1000 * PERIOD_MS;

  state_e       state_q, state_d;
  logic         pending_q, pending_d;
  logic         guard_q, guard_d;
  logic [W-1:0] prime_q, prime_d;
  logic         tick;
  logic         tick_en;
  logic         launch;
  logic         due;

  assign tick_en = !bus.pause;

  tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (tick_en),
    .tick(tick)
  );

  always_comb begin
    state_d   = state_q;
    guard_d   = 1'b0;
    pending_d = pending_q;
    prime_d   = prime_q;
    launch    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.pg_ready && bus.pg_error) begin
          state_d = StErr;
        end else if (pending_q && due && bus.pg_ready && !bus.pause) begin
          launch  = 1'b1;
          prime_d = bus.pg_res;
          guard_d = 1'b1;
          state_d = StBusy;
        end
      end
      StBusy: begin
        // The generator registers pg_go, so pg_ready is stale on the first cycle.
        if (!guard_q && bus.pg_ready) begin
          state_d = bus.pg_error ? StErr : StIdle;
        end
      end
      StErr: begin
        state_d = StErr;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // A coincident tick is absorbed by the launch it rides along with.
    if (state_q != StErr) begin
      if (launch) begin
        pending_d = 1'b0;
      end else if (tick) begin
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= 1'b0;
      guard_q   <= 1'b0;
      prime_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      guard_q   <= guard_d;
      prime_q   <= prime_d;
    end
  end

  assign bus.pg_go   = launch;
  assign bus.err_led = (state_q == StErr);

`ifdef PRIME_DISPLAY_PAGE_EN
  localparam int unsigned NPAGES = ceil_div(W, NLEDS);
  localparam int unsigned PW     = (NPAGES > 1) ? $clog2(NPAGES) : 1;
  localparam logic [PW-1:0] LastPage = PW'(NPAGES - 1);

  logic [PW-1:0]           page_q, page_d;
  logic                    due_q, due_d;
  logic [NPAGES*NLEDS-1:0] prime_pad;

  always_comb begin
    page_d = page_q;
    due_d  = due_q;
    if (launch) begin
      page_d = '0;
      due_d  = 1'b0;
    end else if (tick && state_q != StErr) begin
      if (page_q == LastPage) begin
        page_d = '0;
        due_d  = 1'b1;
      end else begin
        page_d = page_q + 1'b1;
      end
    end
  end

  // Zero-extend so the top page reads 0 above the prime's MSB.
  always_comb begin
    prime_pad          = '0;
    prime_pad[W-1:0]   = prime_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      page_q <= '0;
      due_q  <= 1'b0;
    end else begin
      page_q <= page_d;
      due_q  <= due_d;
    end
  end

  assign due      = due_q;
  assign bus.leds = prime_pad[int'(page_q) * NLEDS +: NLEDS];
`else
  assign due      = 1'b1;
  assign bus.leds = prime_q[NLEDS-1:0];
`endif

endmodule

// File: tb/tb_prime_display.sv
// Directed bench for prime_display with DIV=5, W=16, NLEDS=4.
module tb_prime_display;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  prime_display_if #(.W(16), .NLEDS(4)) bus ();

  prime_display #(
    .CLK_HZ   (1000),
    .PERIOD_MS(5),
    .WIDTH_LOG(4),
    .NLEDS    (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.pause    = 1'b0;
    bus.pg_ready = 1'b1;
    bus.pg_error = 1'b0;
    bus.pg_res   = 16'h0007;
    @(negedge clk);
    #1;
    n_vec++;
    if (bus.pg_go !== 1'b0) begin
      n_err++;
      $display("FAIL reset_pg_go got %b want 0", bus.pg_go);
    end
    n_vec++;
    if (bus.leds !== 4'h0) begin
      n_err++;
      $display("FAIL reset_leds got %h want 0", bus.leds);
    end
    n_vec++;
    if (bus.err_led !== 1'b0) begin
      n_err++;
      $display("FAIL reset_err_led got %b want 0", bus.err_led);
    end
  endtask

  task automatic test_free_run();
    logic exp_go, exp_tick;
    logic [3:0] exp_leds;
    do_reset();
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      #1;
      exp_tick = (i % 5 == 4);
      exp_go   = (i % 5 == 0);
      exp_leds = (i >= 6) ? 4'h7 : 4'h0;
      n_vec++;
      if (dut.u_tick.tick !== exp_tick) begin
        n_err++;
        $display("FAIL free_tick cyc %0d got %b want %b", i, dut.u_tick.tick, exp_tick);
      end
      n_vec++;
      if (bus.pg_go !== exp_go) begin
        n_err++;
        $display("FAIL free_pg_go cyc %0d got %b want %b", i, bus.pg_go, exp_go);
      end
      n_vec++;
      if (bus.leds !== exp_leds) begin
        n_err++;
        $display("FAIL free_leds cyc %0d got %h want %h", i, bus.leds, exp_leds);
      end
    end
  endtask

  task automatic test_ready_low();
    logic exp_go;
    logic [3:0] exp_leds;
    do_reset();
    bus.pg_res = 16'h0003;
    for (int i = 1; i <= 26; i++) begin
      @(negedge clk);
      if (i == 6) bus.pg_res = 16'h0009;
      bus.pg_ready = !(i >= 6 && i <= 17);
      #1;
      exp_go   = (i == 5 || i == 19 || i == 25);
      exp_leds = (i >= 20) ? 4'h9 : (i >= 6) ? 4'h3 : 4'h0;
      n_vec++;
      if (bus.pg_go !== exp_go) begin
        n_err++;
        $display("FAIL rdy_pg_go cyc %0d got %b want %b", i, bus.pg_go, exp_go);
      end
      n_vec++;
      if (bus.leds !== exp_leds) begin
        n_err++;
        $display("FAIL rdy_leds cyc %0d got %h want %h", i, bus.leds, exp_leds);
      end
    end
    bus.pg_ready = 1'b1;
  endtask

  task automatic test_error();
    logic exp_go, exp_err;
    logic [3:0] exp_leds;
    do_reset();
    bus.pg_res = 16'h0005;
    for (int i = 1; i <= 58; i++) begin
      @(negedge clk);
      if (i == 6) begin
        bus.pg_res   = 16'h000E;
        bus.pg_error = 1'b1;
      end
      if (i == 30) bus.pg_error = 1'b0;
      #1;
      exp_go   = (i == 5);
      exp_err  = (i >= 8);
      exp_leds = (i >= 6) ? 4'h5 : 4'h0;
      n_vec++;
      if (bus.pg_go !== exp_go) begin
        n_err++;
        $display("FAIL err_pg_go cyc %0d got %b want %b", i, bus.pg_go, exp_go);
      end
      n_vec++;
      if (bus.err_led !== exp_err) begin
        n_err++;
        $display("FAIL err_led cyc %0d got %b want %b", i, bus.err_led, exp_err);
      end
      n_vec++;
      if (bus.leds !== exp_leds) begin
        n_err++;
        $display("FAIL err_leds cyc %0d got %h want %h", i, bus.leds, exp_leds);
      end
    end
    bus.pg_error = 1'b0;
  endtask

  task automatic test_pause();
    logic exp_go, exp_tick;
    do_reset();
    bus.pg_res = 16'h0002;
    for (int i = 1; i <= 36; i++) begin
      @(negedge clk);
      bus.pause = (i >= 10 && i <= 29);
      #1;
      exp_tick = (i == 4 || i == 9 || i == 34);
      exp_go   = (i == 5 || i == 30 || i == 35);
      n_vec++;
      if (dut.u_tick.tick !== exp_tick) begin
        n_err++;
        $display("FAIL pause_tick cyc %0d got %b want %b", i, dut.u_tick.tick, exp_tick);
      end
      n_vec++;
      if (bus.pg_go !== exp_go) begin
        n_err++;
        $display("FAIL pause_pg_go cyc %0d got %b want %b", i, bus.pg_go, exp_go);
      end
    end
    bus.pause = 1'b0;
  endtask

  task automatic test_reset_busy();
    logic exp_go;
    do_reset();
    bus.pg_res = 16'h000B;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 6) bus.pg_ready = 1'b0;
    end
    #1;
    n_vec++;
    if (bus.leds !== 4'hB) begin
      n_err++;
      $display("FAIL rstbusy_leds_before got %h want b", bus.leds);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.leds !== 4'h0 || bus.pg_go !== 1'b0 || bus.err_led !== 1'b0) begin
      n_err++;
      $display("FAIL rstbusy_async got leds=%h go=%b err=%b want 0 0 0",
               bus.leds, bus.pg_go, bus.err_led);
    end
    @(negedge clk);
    rst          = 1'b0;
    bus.pg_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      #1;
      exp_go = (i == 5);
      n_vec++;
      if (bus.pg_go !== exp_go) begin
        n_err++;
        $display("FAIL rstbusy_pg_go cyc %0d got %b want %b", i, bus.pg_go, exp_go);
      end
    end
  endtask

`ifdef PRIME_DISPLAY_PAGE_EN
  task automatic test_page();
    logic exp_go;
    logic [3:0] exp_leds;
    logic [15:0] val;
    int p;
    do_reset();
    val        = 16'hABCD;
    bus.pg_res = val;
    for (int i = 1; i <= 41; i++) begin
      @(negedge clk);
      #1;
      p        = ((i - 20) / 5) % 4;
      exp_go   = (i == 20 || i == 40);
      exp_leds = (i >= 21) ? 4'((val >> (4 * p)) & 16'hF) : 4'h0;
      n_vec++;
      if (bus.pg_go !== exp_go) begin
        n_err++;
        $display("FAIL page_pg_go cyc %0d got %b want %b", i, bus.pg_go, exp_go);
      end
      n_vec++;
      if (bus.leds !== exp_leds) begin
        n_err++;
        $display("FAIL page_leds cyc %0d got %h want %h", i, bus.leds, exp_leds);
      end
    end
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
`ifdef PRIME_DISPLAY_PAGE_EN
    test_page();
`else
    test_free_run();
    test_ready_low();
    test_error();
    test_pause();
    test_reset_busy();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
